// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronise and filter kclk/kdata, deframe 11-bit frames, merge E0/F0 prefixes into one 32-bit event.
// Latency: a pin edge reaches the filtered level after 2+FILTER_LEN cycles; strobes follow the stop-bit sample event by one cycle.
// Backpressure: none; each event is a one-cycle strobe and the consumer must latch keycodeout. Build option: PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kclk,
    input  logic        kdata,
    output logic [31:0] keycodeout,
    output logic        newkeypress,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Index 0 is kclk, index 1 is kdata.
    logic [1:0]         sync1_q;
    logic [1:0]         sync2_q;
    logic [1:0]         filt_q;
    logic [1:0]         filt_d;
    logic [1:0][FW-1:0] fcnt_q;
    logic [1:0][FW-1:0] fcnt_d;
    logic               kclk_prev_q;
    logic               sample_evt;
    logic               data_bit;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         bit_cnt_q;
    logic [2:0]         bit_cnt_d;
    logic [7:0]         shift_q;
    logic [7:0]         shift_d;
    logic [TW-1:0]      tmo_q;
    logic [TW-1:0]      tmo_d;
    logic [31:0]        acc_q;
    logic [31:0]        acc_d;
    logic [31:0]        keycode_q;
    logic [31:0]        keycode_d;
    logic               newkey_q;
    logic               newkey_d;
    logic               ferr_q;
    logic               ferr_d;
    logic               frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic               par_q;
    logic               par_d;
`endif

    // Filter: the level flips only after FILTER_LEN consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FLT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Synchroniser, filter and edge-detect registers; idle pin level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            fcnt_q      <= '0;
            kclk_prev_q <= 1'b1;
        end else begin
            sync1_q     <= {kdata, kclk};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            kclk_prev_q <= filt_q[0];
        end
    end

    assign sample_evt = kclk_prev_q & ~filt_q[0];
    assign data_bit   = filt_q[1];

    // Frame FSM next-state, byte delivery and timeout abort.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        acc_d     = acc_q;
        keycode_d = keycode_q;
        newkey_d  = 1'b0;
        ferr_d    = 1'b0;
        frame_ok  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (sample_evt) begin
            tmo_d = '0;
        end else if (state_q != ST_IDLE) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                // A falling edge with data high is a stray edge, not a start bit.
                if (sample_evt && !data_bit) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (sample_evt) begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                // Without parity checking the bit's edge is simply consumed.
                if (sample_evt) begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d   = data_bit;
`endif
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_evt) begin
                    state_d = ST_IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    frame_ok = data_bit & (^{shift_q, par_q});
`else
                    frame_ok = data_bit;
`endif
                    if (!frame_ok) begin
                        ferr_d = 1'b1;
                    end else if (shift_q == 8'hE0 || shift_q == 8'hF0) begin
                        acc_d = {acc_q[23:0], shift_q};
                    end else begin
                        keycode_d = {acc_q[23:0], shift_q};
                        newkey_d  = 1'b1;
                        acc_d     = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A real edge on the threshold cycle wins; otherwise the partial frame is dropped and acc is kept.
        if (state_q != ST_IDLE && !sample_evt && tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            ferr_d  = 1'b1;
        end
    end

    // Frame FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            acc_q     <= '0;
            keycode_q <= '0;
            newkey_q  <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            acc_q     <= acc_d;
            keycode_q <= keycode_d;
            newkey_q  <= newkey_d;
            ferr_q    <= ferr_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    assign keycodeout  = keycode_q;
    assign newkeypress = newkey_q;
    assign frame_err   = ferr_q;

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host receiver for the keyboard path. Synchronises and glitch-filters the raw `kclk`/`kdata` pins, deframes 11-bit PS/2 frames, and merges `E0`/`F0` prefix bytes into one key event. It presents each completed event as a 32-bit scancode plus a one-cycle strobe. It sits directly upstream of the keyboard MMIO/IRQ wrapper, which rising-edge-detects `newkeypress` and latches `keycodeout`.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- `FILTER_LEN`, default 8: consecutive equal synchronised samples needed before the filtered `kclk`/`kdata` level changes.
- `TIMEOUT_CYC`, default 125000: idle `clk` cycles allowed between `kclk` falling edges inside a frame before the frame is aborted (2 ms at 62.5 MHz).
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous active-high reset.
- `kclk`, input, 1: raw PS/2 clock pin, asynchronous.
- `kdata`, input, 1: raw PS/2 data pin, asynchronous.
- `keycodeout`, output, 32: last completed key event, bytes right-aligned, oldest byte in the upper bits, unused upper bytes zero.
- `newkeypress`, output, 1: one-cycle pulse when `keycodeout` is updated.
- `frame_err`, output, 1: one-cycle pulse when a frame is discarded.

## Operation
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser, then a saturating counter filter of `FILTER_LEN` samples.
  - Filtered levels reset to 1.
  - A sample event is a 1→0 transition of the filtered `kclk`.
- Frame FSM, advanced only on sample events, sampling filtered `kdata`:
  - IDLE: data 0 → DATA with bit count 0. Data 1 → stay in IDLE (spurious edge, no error).
  - DATA: shift data in LSB-first. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: stop bit 1 and frame OK → deliver the byte, then IDLE. Otherwise pulse `frame_err`, then IDLE.
- Timeout:
  - Applies in any non-IDLE state.
  - A counter cleared on every sample event reaches `TIMEOUT_CYC` → abort, pulse `frame_err`, return to IDLE.
  - The partial byte is discarded. The sequence accumulator is kept.
- Byte delivery uses a 32-bit accumulator `acc`, reset to 0:
  - Byte `E0` or `F0`: `acc <= {acc[23:0], byte}`. No strobe.
  - Any other byte: `keycodeout <= {acc[23:0], byte}`, pulse `newkeypress`, then `acc <= 0`.
  - With more than three prefixes, the oldest bytes fall off the top; no error is raised.
- Example: make code `1C` → `0x0000001C`. Break of right-ctrl (`E0 F0 14`) → `0x00E0F014`.

## Timing
- Reset values: `keycodeout` = 0, `newkeypress` = 0, `frame_err` = 0, FSM = IDLE, `acc` = 0, timeout counter = 0, filtered levels = 1.
- Reset asserted mid-frame: the next cycle is in IDLE with `acc` cleared. No strobe or error is issued for the aborted frame.
- Pin-to-sample latency: a stable pin change is reflected in the filtered level 2 + `FILTER_LEN` cycles later. The sample event occurs on that cycle.
- Strobe timing:
  - `newkeypress` or `frame_err` goes high the cycle after the stop-bit sample event (or the cycle after the timeout count is reached).
  - Each pulse lasts exactly one cycle.
  - `newkeypress` and `frame_err` are never high together.
- `keycodeout` changes only in the cycle `newkeypress` is high, and holds until the next event.
- Minimum spacing between strobes is one full frame, so the consumer's edge detector never misses a pulse.
- A falling edge arriving on the same cycle as the timeout threshold: the sample event wins and the counter clears.
- Filtered `kdata` is sampled on the same cycle as the `kclk` sample event. Data must be stable for `FILTER_LEN` cycles around the edge, which PS/2 timing guarantees.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: STOP accepts the frame only if the 8 data bits plus the parity bit have odd parity. A parity mismatch discards the byte (`acc` unchanged) and pulses `frame_err`.
  - Undefined: the parity bit is captured and ignored. Only the start and stop bits are checked.

## Test plan
- Reset, then a clean frame for byte `1C` (odd parity 0, stop 1) → after the stop edge, one-cycle `newkeypress`, `keycodeout` = `0x0000001C`, `frame_err` stays 0.
- Three frames `E0`, `F0`, `14` → exactly one `newkeypress`, after the third frame, `keycodeout` = `0x00E0F014`. Then frame `1C` → `keycodeout` = `0x0000001C`.
- Byte `1C` with parity bit 1:
  - With `PS2_PARITY_CHECK_EN` → one `frame_err`, no `newkeypress`, `keycodeout` unchanged.
  - Without it → `newkeypress` and `keycodeout` = `0x0000001C`.
- Stop bit 0, or `kclk` held high for `TIMEOUT_CYC` + 10 cycles after 4 data bits → `frame_err` pulse, FSM back in IDLE. The next clean frame `29` decodes to `0x00000029`.
- Glitches on `kclk`, low for `FILTER_LEN` − 1 cycles, injected mid-bit → no extra sample event, frame decodes correctly.
- `rst` asserted after frame `E0` and halfway through a following frame → outputs return to 0. The next frame `1C` yields `0x0000001C`, with no `E0` prefix.
